// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// Purely declarative; no logic and no latency.
// Default widths match the sram_ctrl port used by the UART checker and the BIST engine.
package sram_arb_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      HOLD  = 3'd2,
      WAIT  = 3'd3,
      DONE  = 3'd4
   } arb_state_t;

   // Requester indices: port 0 = UART command checker, port 1 = BIST engine.
   localparam logic P0 = 1'b0;
   localparam logic P1 = 1'b1;

   localparam int SRAM_ADDR_W = 19;
   localparam int SRAM_DATA_W = 8;

   // One-hot strobe vector selecting the given port's ack/done.
   function automatic logic [1:0] port_onehot(input logic port);
      return port ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way request picker: round-robin on last_grant, or port 0 first when FIXED_PRIO=1.
// Latency: purely combinational, the grant register lives in the parent.
// Backpressure: none of its own; the parent only consults it while idle.
module sram_arb_rr
   import sram_arb_pkg::*;
#(
   parameter int FIXED_PRIO = 0
) (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic       winner,
   output logic       any
);

   // A lone request always wins; a tie goes to port 0 or to whoever did not win last.
   always_comb begin
      any    = |valid;
      winner = P0;
      if (valid == 2'b11) begin
         winner = (FIXED_PRIO != 0) ? P0 : ~last_grant;
      end else if (valid[1]) begin
         winner = P1;
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one sram_ctrl port between the UART checker (port 0) and the BIST engine (port 1).
// Latency: ack 1 clk after valid, mem strobe at +2, done at +3 + sram busy cycles + 1.
// Backpressure: requests are held (no ack) while sram_ctrl is not ready or another access is in flight.
// Optional watchdog on the WAIT state: define SRAM_ARB_TIMEOUT_EN.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W         = SRAM_ADDR_W,
   parameter int DATA_W         = SRAM_DATA_W,
   parameter int FIXED_PRIO     = 0,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              req0_valid,
   input  logic              req0_rw,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ack,
   output logic              req0_done,
   output logic [DATA_W-1:0] req0_rdata,

   input  logic              req1_valid,
   input  logic              req1_rw,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ack,
   output logic              req1_done,
   output logic [DATA_W-1:0] req1_rdata,

   output logic              mem,
   output logic              rw,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data_f2s,
   input  logic              ready,
   input  logic [DATA_W-1:0] data_s2f_r,

   output logic              err
);

   arb_state_t        state, state_nxt;
   logic              grant_q, grant_nxt;
   logic              last_grant, last_grant_nxt;
   logic              pick, pick_any;
   logic              mem_nxt, rw_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [DATA_W-1:0] wdata_nxt;
   logic [1:0]        ack_nxt, done_nxt;
   logic [DATA_W-1:0] rdata0_nxt, rdata1_nxt;

`ifdef SRAM_ARB_TIMEOUT_EN
   localparam int              TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0] to_cnt, to_cnt_nxt;
   logic            err_nxt;
`endif

   sram_arb_rr #(
      .FIXED_PRIO (FIXED_PRIO)
   ) u_rr (
      .valid      ({req1_valid, req0_valid}),
      .last_grant (last_grant),
      .winner     (pick),
      .any        (pick_any)
   );

   // State register; reset drops any in-flight access without a done.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state plus next value of every registered output.
   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant_q;
      last_grant_nxt = last_grant;
      mem_nxt        = 1'b0;
      rw_nxt         = rw;
      addr_nxt       = addr;
      wdata_nxt      = data_f2s;
      ack_nxt        = 2'b00;
      done_nxt       = 2'b00;
      rdata0_nxt     = req0_rdata;
      rdata1_nxt     = req1_rdata;
`ifdef SRAM_ARB_TIMEOUT_EN
      to_cnt_nxt     = to_cnt;
      err_nxt        = err;
`endif
      unique case (state)
         IDLE: begin
            if (ready && pick_any) begin
               grant_nxt = pick;
               rw_nxt    = pick ? req1_rw    : req0_rw;
               addr_nxt  = pick ? req1_addr  : req0_addr;
               wdata_nxt = pick ? req1_wdata : req0_wdata;
               ack_nxt   = port_onehot(pick);
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            mem_nxt   = 1'b1;
            state_nxt = HOLD;
`ifdef SRAM_ARB_TIMEOUT_EN
            to_cnt_nxt = '0;
`endif
         end
         HOLD: begin
            // sram_ctrl only drops ready after seeing mem, so ready is meaningless here.
            state_nxt = WAIT;
`ifdef SRAM_ARB_TIMEOUT_EN
            to_cnt_nxt = to_cnt + 1'b1;
`endif
         end
         WAIT: begin
`ifdef SRAM_ARB_TIMEOUT_EN
            to_cnt_nxt = to_cnt + 1'b1;
`endif
            if (ready) begin
               if (rw) begin
                  if (grant_q) rdata1_nxt = data_s2f_r;
                  else         rdata0_nxt = data_s2f_r;
               end
               done_nxt  = port_onehot(grant_q);
               state_nxt = DONE;
            end
`ifdef SRAM_ARB_TIMEOUT_EN
            else if (to_cnt == TO_LAST) begin
               // Give up on a hung sram_ctrl: flag it and release the requester with zero data.
               err_nxt        = 1'b1;
               if (grant_q) rdata1_nxt = '0;
               else         rdata0_nxt = '0;
               done_nxt       = port_onehot(grant_q);
               last_grant_nxt = grant_q;
               state_nxt      = IDLE;
            end
`endif
         end
         DONE: begin
            last_grant_nxt = grant_q;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Registered outputs and arbitration history.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant_q    <= P0;
         last_grant <= P1;
         mem        <= 1'b0;
         rw         <= 1'b0;
         addr       <= '0;
         data_f2s   <= '0;
         req0_ack   <= 1'b0;
         req1_ack   <= 1'b0;
         req0_done  <= 1'b0;
         req1_done  <= 1'b0;
         req0_rdata <= '0;
         req1_rdata <= '0;
      end else begin
         grant_q    <= grant_nxt;
         last_grant <= last_grant_nxt;
         mem        <= mem_nxt;
         rw         <= rw_nxt;
         addr       <= addr_nxt;
         data_f2s   <= wdata_nxt;
         req0_ack   <= ack_nxt[0];
         req1_ack   <= ack_nxt[1];
         req0_done  <= done_nxt[0];
         req1_done  <= done_nxt[1];
         req0_rdata <= rdata0_nxt;
         req1_rdata <= rdata1_nxt;
      end
   end

`ifdef SRAM_ARB_TIMEOUT_EN
   // Watchdog counter and sticky error flag; err only clears on reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         to_cnt <= '0;
         err    <= 1'b0;
      end else begin
         to_cnt <= to_cnt_nxt;
         err    <= err_nxt;
      end
   end
`else
   assign err = 1'b0;

   // The limit has no effect without the watchdog; this empty block keeps it referenced.
   if (TIMEOUT_CYCLES < 2) begin : g_timeout_unused
   end
`endif

endmodule
